// File: rtl/pong_ball.sv
// pong_ball: moves a square ball once per frame (strobe at sx==0,sy==0) with wall bounces and flags raster pixels inside it.
// Position/bounce update one cycle after the strobe, ball_pix lags its raster inputs by one cycle; no backpressure (free-running).
module pong_ball #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int H_ORIGIN    = 48,
  parameter int V_ORIGIN    = 33,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int START_X     = 316,
  parameter int START_Y     = 236,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       pix_clk,
  input  logic       rst_pix,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       de,
  input  logic       run,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_pix,
  output logic       bounce
);

  localparam logic [10:0] H_RES_W   = 11'(H_RES);
  localparam logic [10:0] V_RES_W   = 11'(V_RES);
  localparam logic [10:0] SIZE_W    = 11'(BALL_SIZE);
  localparam logic [10:0] SPEED_W   = 11'(SPEED);
  localparam logic [10:0] H_ORG_W   = 11'(H_ORIGIN);
  localparam logic [10:0] V_ORG_W   = 11'(V_ORIGIN);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

  typedef enum logic {HOLD, MOVE} state_t;

  state_t      state;
  logic [7:0]  hold_cnt;
  logic        dx;
  logic        dy;

  // Returns {reflect, new_dir, new_pos}; the wall clamp keeps the ball inside the active area.
  function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] res);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir) begin
      if (p + SPEED_W + SIZE_W >= res) axis_step = {1'b1, 1'b0, 10'(res - SIZE_W)};
      else                             axis_step = {1'b0, 1'b1, 10'(p + SPEED_W)};
    end else begin
      if (p <= SPEED_W) axis_step = {1'b1, 1'b1, 10'd0};
      else              axis_step = {1'b0, 1'b0, 10'(p - SPEED_W)};
    end
  endfunction

  logic        frame_tick;
  logic [11:0] step_x;
  logic [11:0] step_y;

  assign frame_tick = (sx == 10'd0) && (sy == 10'd0);
  assign step_x     = axis_step(ball_x, dx, H_RES_W);
  assign step_y     = axis_step(ball_y, dy, V_RES_W);

  // Raster positions left of / above the origin wrap to a set MSB and never hit.
  logic [10:0] hx;
  logic [10:0] hy;
  logic [10:0] bx;
  logic [10:0] by;
  logic        in_x;
  logic        in_y;

  assign hx   = {1'b0, sx} - H_ORG_W;
  assign hy   = {1'b0, sy} - V_ORG_W;
  assign bx   = {1'b0, ball_x};
  assign by   = {1'b0, ball_y};
  assign in_x = !hx[10] && (hx >= bx) && (hx < bx + SIZE_W);
  assign in_y = !hy[10] && (hy >= by) && (hy < by + SIZE_W);

  always_ff @(posedge pix_clk or posedge rst_pix) begin
    if (rst_pix) begin
      state    <= HOLD;
      hold_cnt <= 8'd0;
      ball_x   <= 10'(START_X);
      ball_y   <= 10'(START_Y);
      dx       <= 1'b1;
      dy       <= 1'b1;
      ball_pix <= 1'b0;
      bounce   <= 1'b0;
    end else begin
      ball_pix <= de && in_x && in_y;
      bounce   <= 1'b0;
      if (frame_tick) begin
        case (state)
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= MOVE;
              hold_cnt <= 8'd0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
          MOVE: begin
            if (run) begin
              ball_x <= step_x[9:0];
              dx     <= step_x[10];
              ball_y <= step_y[9:0];
              dy     <= step_y[10];
              bounce <= step_x[11] | step_y[11];
            end
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

endmodule
